// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone memory arbiter: FSM state encoding and grant status codes.
package wb_arb_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned SEL_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_I = 2'b01,
    ST_GNT_D = 2'b10
  } arb_state_e;

  localparam logic [1:0]           GNT_NONE = 2'b00;
  localparam logic [1:0]           GNT_I    = 2'b01;
  localparam logic [1:0]           GNT_D    = 2'b10;
  localparam logic [SEL_WIDTH-1:0] SEL_ALL  = 4'hF;

  // Status code reported on grant_o for a given arbiter state.
  function automatic logic [1:0] grant_code(input arb_state_e s);
    case (s)
      ST_GNT_I: grant_code = GNT_I;
      ST_GNT_D: grant_code = GNT_D;
      default:  grant_code = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Per-access watchdog for Wishbone bridges: counts stalled strobe cycles and flags
// expiry on the LIMIT-th cycle without a response. LIMIT of 0 disables it.
module wb_timeout_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = (LIMIT == 0) ? '0 : WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q;

  assign expired = (LIMIT != 0) && run && !clear && (count_q == LAST);

  // Saturating count; expiry restarts the next access from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear || expired) begin
      count_q <= '0;
    end else if (run && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-to-one Wishbone classic arbiter sharing one memory slave between the instruction
// and data masters, with round-robin ties, burst-held grants and a hung-slave watchdog.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] iwbs_addr_i,
  input  logic                  iwbs_cyc_i,
  input  logic                  iwbs_stb_i,
  output logic [DATA_WIDTH-1:0] iwbs_dat_o,
  output logic                  iwbs_ack_o,
  output logic                  iwbs_err_o,
  input  logic [ADDR_WIDTH-1:0] dwbs_addr_i,
  input  logic [DATA_WIDTH-1:0] dwbs_dat_i,
  input  logic [SEL_WIDTH-1:0]  dwbs_sel_i,
  input  logic                  dwbs_cyc_i,
  input  logic                  dwbs_stb_i,
  input  logic                  dwbs_we_i,
  output logic [DATA_WIDTH-1:0] dwbs_dat_o,
  output logic                  dwbs_ack_o,
  output logic                  dwbs_err_o,
  output logic [ADDR_WIDTH-1:0] wbm_addr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  output logic [SEL_WIDTH-1:0]  wbm_sel_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic [1:0]            grant_o
);

  localparam int unsigned TO_WIDTH = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  arb_state_e state_q, state_d;
  logic       last_d_q;
  logic       i_req, d_req;
  logic       gnt_stb;
  logic       wd_clear;
  logic       wd_expired;

  assign i_req = iwbs_cyc_i & iwbs_stb_i;
  assign d_req = dwbs_cyc_i & dwbs_stb_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_GNT_I && state_q != ST_GNT_I) last_d_q <= 1'b0;
      if (state_d == ST_GNT_D && state_q != ST_GNT_D) last_d_q <= 1'b1;
    end
  end

  // Grant is only released when the owning master drops cyc; ties go to the other master.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req && d_req) state_d = last_d_q ? ST_GNT_I : ST_GNT_D;
        else if (i_req)     state_d = ST_GNT_I;
        else if (d_req)     state_d = ST_GNT_D;
      end
      ST_GNT_I: if (!iwbs_cyc_i) state_d = d_req ? ST_GNT_D : ST_IDLE;
      ST_GNT_D: if (!dwbs_cyc_i) state_d = i_req ? ST_GNT_I : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_stb = 1'b0;
    case (state_q)
      ST_GNT_I: gnt_stb = iwbs_stb_i;
      ST_GNT_D: gnt_stb = dwbs_stb_i;
      default:  gnt_stb = 1'b0;
    endcase
  end

  assign wd_clear = !gnt_stb || wbm_ack_i || wbm_err_i;

  wb_timeout_counter #(
    .WIDTH (TO_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (wd_clear),
    .run     (gnt_stb),
    .expired (wd_expired)
  );

  // Slave-side request mux and response steering to the granted master only.
  always_comb begin
    wbm_addr_o = '0;
    wbm_dat_o  = '0;
    wbm_sel_o  = '0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    iwbs_ack_o = 1'b0;
    iwbs_err_o = 1'b0;
    dwbs_ack_o = 1'b0;
    dwbs_err_o = 1'b0;
    case (state_q)
      ST_GNT_I: begin
        wbm_addr_o = iwbs_addr_i;
        wbm_sel_o  = SEL_ALL;
        wbm_cyc_o  = iwbs_cyc_i;
        wbm_stb_o  = iwbs_stb_i & ~wd_expired;
        iwbs_ack_o = wbm_ack_i;
        iwbs_err_o = wbm_err_i | wd_expired;
      end
      ST_GNT_D: begin
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_cyc_o  = dwbs_cyc_i;
        wbm_stb_o  = dwbs_stb_i & ~wd_expired;
        wbm_we_o   = dwbs_we_i;
        dwbs_ack_o = wbm_ack_i;
        dwbs_err_o = wbm_err_i | wd_expired;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; it is only squashed while reset is held.
  assign iwbs_dat_o = rst_i ? '0 : wbm_dat_i;
  assign dwbs_dat_o = rst_i ? '0 : wbm_dat_i;
  assign grant_o    = grant_code(state_q);

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboard bench for wb_mem_arbiter: directed master stimulus, behavioural slave,
// and a negedge monitor matching every ack/err against queued expectations.
module tb_wb_mem_arbiter;

  localparam int unsigned AW = 32;

  typedef struct packed {
    logic        port;  // 0 instruction, 1 data
    logic        err;
    logic [31:0] dat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] iwbs_addr = '0;
  logic          iwbs_cyc = 1'b0, iwbs_stb = 1'b0;
  logic [31:0]   iwbs_dat;
  logic          iwbs_ack, iwbs_err;
  logic [AW-1:0] dwbs_addr = '0;
  logic [31:0]   dwbs_wdat = '0;
  logic [3:0]    dwbs_sel = '0;
  logic          dwbs_cyc = 1'b0, dwbs_stb = 1'b0, dwbs_we = 1'b0;
  logic [31:0]   dwbs_dat;
  logic          dwbs_ack, dwbs_err;
  logic [AW-1:0] wbm_addr;
  logic [31:0]   wbm_wdat;
  logic [3:0]    wbm_sel;
  logic          wbm_cyc, wbm_stb, wbm_we;
  logic [31:0]   s_dat = 32'h0;
  logic          s_ack, s_err;
  logic [1:0]    grant;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  int   ack_delay = 2;
  bit   slave_noack = 1'b0;
  bit   slave_err = 1'b0;
  int   s_wait;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .iwbs_addr_i(iwbs_addr), .iwbs_cyc_i(iwbs_cyc), .iwbs_stb_i(iwbs_stb),
    .iwbs_dat_o(iwbs_dat), .iwbs_ack_o(iwbs_ack), .iwbs_err_o(iwbs_err),
    .dwbs_addr_i(dwbs_addr), .dwbs_dat_i(dwbs_wdat), .dwbs_sel_i(dwbs_sel),
    .dwbs_cyc_i(dwbs_cyc), .dwbs_stb_i(dwbs_stb), .dwbs_we_i(dwbs_we),
    .dwbs_dat_o(dwbs_dat), .dwbs_ack_o(dwbs_ack), .dwbs_err_o(dwbs_err),
    .wbm_addr_o(wbm_addr), .wbm_dat_o(wbm_wdat), .wbm_sel_o(wbm_sel),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
    .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err),
    .grant_o(grant)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // Behavioural slave: responds ack_delay cycles after stb first reaches it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack <= 1'b0; s_err <= 1'b0; s_wait <= 0;
    end else begin
      s_ack <= 1'b0; s_err <= 1'b0;
      if (wbm_cyc && wbm_stb && !s_ack && !s_err && !slave_noack) begin
        if (s_wait == ack_delay - 1) begin
          s_wait <= 0;
          s_dat  <= mem_rd(wbm_addr);
          if (slave_err) s_err <= 1'b1; else s_ack <= 1'b1;
        end else begin
          s_wait <= s_wait + 1;
        end
      end else if (!wbm_stb) begin
        s_wait <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every response on either master port must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && (iwbs_ack || iwbs_err || dwbs_ack || dwbs_err)) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_resp: got i_ack=%b i_err=%b d_ack=%b d_err=%b expected none",
                 iwbs_ack, iwbs_err, dwbs_ack, dwbs_err);
      end else begin
        exp_t e;
        logic [3:0] got, want;
        e    = exp_q.pop_front();
        got  = {iwbs_ack, iwbs_err, dwbs_ack, dwbs_err};
        want = {!e.port && !e.err, !e.port && e.err, e.port && !e.err, e.port && e.err};
        chk("resp_flags", 32'(got), 32'(want));
        if (!e.err) chk("resp_data", e.port ? dwbs_dat : iwbs_dat, e.dat);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input bit d);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = d ? (dwbs_ack | dwbs_err) : (iwbs_ack | iwbs_err);
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL resp_timeout: got no response on %s port expected one", d ? "data" : "instr");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push(input logic port, input logic err, input logic [31:0] dat);
    exp_t e;
    e.port = port; e.err = err; e.dat = dat;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_grant", 32'(grant), 32'h0);

    // Single instruction read
    tick();
    iwbs_addr = 32'h8000_0000; iwbs_cyc = 1'b1; iwbs_stb = 1'b1;
    push(1'b0, 1'b0, mem_rd(32'h8000_0000));
    @(negedge clk); chk("t1_grant_before", 32'(grant), 32'h0);
    @(negedge clk); chk("t1_grant_after", 32'(grant), 32'h1);
    chk("t1_wbm_stb", 32'(wbm_stb), 32'h1);
    chk("t1_wbm_addr", wbm_addr, 32'h8000_0000);
    chk("t1_wbm_sel", 32'(wbm_sel), 32'hF);
    chk("t1_wbm_we", 32'(wbm_we), 32'h0);
    wait_resp(1'b0);
    chk("t1_d_ack_quiet", 32'(dwbs_ack), 32'h0);
    tick(); iwbs_cyc = 1'b0; iwbs_stb = 1'b0;
    tick(); tick();

    // Simultaneous requests after reset: data first, then instruction with no idle gap
    do_reset();
    tick();
    iwbs_addr = 32'h0000_0100; iwbs_cyc = 1'b1; iwbs_stb = 1'b1;
    dwbs_addr = 32'h0000_2000; dwbs_cyc = 1'b1; dwbs_stb = 1'b1; dwbs_sel = 4'hF;
    push(1'b1, 1'b0, mem_rd(32'h0000_2000));
    push(1'b0, 1'b0, mem_rd(32'h0000_0100));
    @(negedge clk); @(negedge clk);
    chk("t2_grant_data", 32'(grant), 32'h2);
    wait_resp(1'b1);
    tick(); dwbs_cyc = 1'b0; dwbs_stb = 1'b0;
    @(negedge clk); chk("t2_grant_hold", 32'(grant), 32'h2);
    @(negedge clk); chk("t2_grant_switch", 32'(grant), 32'h1);
    wait_resp(1'b0);
    tick(); iwbs_cyc = 1'b0; iwbs_stb = 1'b0;
    tick(); tick();

    // Data burst of three beats holds the grant against a waiting instruction master
    tick();
    dwbs_addr = 32'h0000_3000; dwbs_cyc = 1'b1; dwbs_stb = 1'b1;
    push(1'b1, 1'b0, mem_rd(32'h0000_3000));
    @(negedge clk); @(negedge clk);
    chk("t3_grant_data", 32'(grant), 32'h2);
    tick(); iwbs_addr = 32'h0000_0200; iwbs_cyc = 1'b1; iwbs_stb = 1'b1;
    for (int b = 1; b < 3; b++) begin
      wait_resp(1'b1);
      chk("t3_grant_held", 32'(grant), 32'h2);
      tick();
      dwbs_addr = 32'h0000_3000 + 32'(4 * b);
      push(1'b1, 1'b0, mem_rd(dwbs_addr));
    end
    push(1'b0, 1'b0, mem_rd(32'h0000_0200));
    wait_resp(1'b1);
    chk("t3_grant_last_beat", 32'(grant), 32'h2);
    tick(); dwbs_cyc = 1'b0; dwbs_stb = 1'b0;
    @(negedge clk); chk("t3_grant_cyc_low", 32'(grant), 32'h2);
    @(negedge clk); chk("t3_grant_instr", 32'(grant), 32'h1);
    wait_resp(1'b0);
    tick(); iwbs_cyc = 1'b0; iwbs_stb = 1'b0;
    tick(); tick();

    // Hung slave on a data write: watchdog err on the 8th strobe cycle
    slave_noack = 1'b1;
    tick();
    dwbs_addr = 32'h0000_4000; dwbs_wdat = 32'hCAFE_F00D; dwbs_sel = 4'h3;
    dwbs_we = 1'b1; dwbs_cyc = 1'b1; dwbs_stb = 1'b1;
    push(1'b1, 1'b1, 32'h0);
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("t4_wbm_we", 32'(wbm_we), 32'h1);
        chk("t4_wbm_sel", 32'(wbm_sel), 32'h3);
        chk("t4_wbm_dat", wbm_wdat, 32'hCAFE_F00D);
      end
      chk($sformatf("t4_err_cyc%0d", k), 32'(dwbs_err), (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("t4_stb_cyc%0d", k), 32'(wbm_stb), (k == 8) ? 32'h0 : 32'h1);
    end
    tick(); dwbs_cyc = 1'b0; dwbs_stb = 1'b0; dwbs_we = 1'b0;
    tick(); tick();

    // Slave err on a fetch, then a slow ack on the same cycle proves the watchdog restarted
    slave_noack = 1'b0; slave_err = 1'b1; ack_delay = 6;
    tick();
    iwbs_addr = 32'h0000_0500; iwbs_cyc = 1'b1; iwbs_stb = 1'b1;
    push(1'b0, 1'b1, 32'h0);
    wait_resp(1'b0);
    chk("t6_i_ack_low", 32'(iwbs_ack), 32'h0);
    tick();
    slave_err = 1'b0; iwbs_addr = 32'h0000_0504;
    push(1'b0, 1'b0, mem_rd(32'h0000_0504));
    wait_resp(1'b0);
    tick(); iwbs_cyc = 1'b0; iwbs_stb = 1'b0;
    tick(); tick();

    // Asynchronous reset in the middle of an instruction access
    ack_delay = 2; slave_noack = 1'b1;
    tick();
    iwbs_addr = 32'h0000_0600; iwbs_cyc = 1'b1; iwbs_stb = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("t5_grant_pre", 32'(grant), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_grant", 32'(grant), 32'h0);
    chk("t5_rst_cyc", 32'(wbm_cyc), 32'h0);
    chk("t5_rst_stb", 32'(wbm_stb), 32'h0);
    chk("t5_rst_addr", wbm_addr, 32'h0);
    chk("t5_rst_idat", iwbs_dat, 32'h0);
    chk("t5_rst_ddat", dwbs_dat, 32'h0);
    chk("t5_rst_iresp", 32'({iwbs_ack, iwbs_err}), 32'h0);
    iwbs_cyc = 1'b0; iwbs_stb = 1'b0; slave_noack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    iwbs_addr = 32'h0000_0700; iwbs_cyc = 1'b1; iwbs_stb = 1'b1;
    dwbs_addr = 32'h0000_5000; dwbs_cyc = 1'b1; dwbs_stb = 1'b1; dwbs_sel = 4'hF;
    push(1'b1, 1'b0, mem_rd(32'h0000_5000));
    push(1'b0, 1'b0, mem_rd(32'h0000_0700));
    @(negedge clk); @(negedge clk);
    chk("t5_grant_data", 32'(grant), 32'h2);
    wait_resp(1'b1);
    tick(); dwbs_cyc = 1'b0; dwbs_stb = 1'b0;
    wait_resp(1'b0);
    tick(); iwbs_cyc = 1'b0; iwbs_stb = 1'b0;
    tick(); tick();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
